// File: rtl/booth_mac_acc_if.sv
// Job, operand and result handshake bundle for the Booth multiply-accumulate stage.
// The master side issues jobs and operands; the slave side is the accumulator.
interface booth_mac_acc_if #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
);
  logic                    start;
  logic [CNT_W-1:0]        len;
  logic                    in_valid;
  logic                    in_ready;
  logic [3:0]              m;
  logic [3:0]              q;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    sat;
  logic                    busy;

  modport master (
    output start, len, in_valid, m, q, out_ready,
    input  in_ready, out_valid, acc_out, sat, busy
  );

  modport slave (
    input  start, len, in_valid, m, q, out_ready,
    output in_ready, out_valid, acc_out, sat, busy
  );
endinterface

// File: rtl/booth_mac_acc.sv
// Signed 4x4 radix-2 Booth multiplier feeding a job-based saturating accumulator
// with valid/ready operand and result ports.
module booth_multi_top (
  input  logic [3:0] M,
  input  logic [3:0] Q,
  output logic [7:0] P
);
  logic [4:0] q_ext;
  logic [7:0] m_ext;
  logic [7:0] m_neg;
  logic [7:0] pp [4];

  assign q_ext = {Q, 1'b0};
  assign m_ext = {{4{M[3]}}, M};
  assign m_neg = ~m_ext + 8'd1;

  // Each Booth digit (q[i], q[i-1]) selects +M, -M or 0, weighted by 2^i.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_pp
      assign pp[gi] = (q_ext[gi+1:gi] == 2'b01) ? (m_ext << gi) :
                      (q_ext[gi+1:gi] == 2'b10) ? (m_neg << gi) : 8'd0;
    end
  endgenerate

  assign P = pp[0] + pp[1] + pp[2] + pp[3];
endmodule

module booth_mac_acc #(
  parameter int ACC_W = 12,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  booth_mac_acc_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  state_t                  state_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    sat_reg;
  logic [CNT_W-1:0]        remaining_reg;
  logic [7:0]              prod_reg;
  logic                    prod_v_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic                    busy_reg;

  logic [7:0]              product;
  logic                    accept;
  logic [CNT_W-1:0]        remaining_dec;
  logic [ACC_W:0]          sum_ext;
  logic                    add_pos_ovf;
  logic                    add_neg_ovf;
  logic signed [ACC_W-1:0] add_result;

  booth_multi_top u_booth (
    .M (bus.m),
    .Q (bus.q),
    .P (product)
  );

  // in_ready_reg is only ever high in ACC, so it alone qualifies the accept.
  assign accept        = bus.in_valid & in_ready_reg;
  assign remaining_dec = remaining_reg - {{(CNT_W-1){1'b0}}, 1'b1};

  // One guard bit is enough: |product| <= 64 never exceeds half the accumulator range.
  assign sum_ext     = {acc_reg[ACC_W-1], acc_reg} + {{(ACC_W-7){prod_reg[7]}}, prod_reg};
  assign add_pos_ovf = ~sum_ext[ACC_W] &  sum_ext[ACC_W-1];
  assign add_neg_ovf =  sum_ext[ACC_W] & ~sum_ext[ACC_W-1];
  assign add_result  = add_pos_ovf ? ACC_MAX :
                       add_neg_ovf ? ACC_MIN : sum_ext[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      sat_reg       <= 1'b0;
      remaining_reg <= '0;
      prod_reg      <= '0;
      prod_v_reg    <= 1'b0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            acc_reg       <= '0;
            sat_reg       <= 1'b0;
            prod_v_reg    <= 1'b0;
            remaining_reg <= bus.len;
            busy_reg      <= 1'b1;
            if (bus.len == '0) begin
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
              in_ready_reg  <= 1'b0;
            end else begin
              state_reg     <= ACC;
              in_ready_reg  <= 1'b1;
            end
          end
        end

        ACC: begin
          if (accept) begin
            prod_reg      <= product;
            prod_v_reg    <= 1'b1;
            remaining_reg <= remaining_dec;
          end else begin
            prod_v_reg    <= 1'b0;
          end

          if (prod_v_reg) begin
            acc_reg <= add_result;
            if (add_pos_ovf || add_neg_ovf) begin
              sat_reg <= 1'b1;
            end
          end

          // The edge that adds the final product is also the one that leaves ACC.
          if (remaining_reg == '0 && prod_v_reg) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            in_ready_reg  <= 1'b0;
          end else if (accept) begin
            in_ready_reg  <= (remaining_dec != '0);
          end else begin
            in_ready_reg  <= (remaining_reg != '0);
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end

        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b0;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.acc_out   = acc_reg;
  assign bus.sat       = sat_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_booth_mac_acc.sv
// Directed, table-driven bench for booth_mac_acc with a 10-bit accumulator so
// that 15-term jobs reach both saturation limits.
module tb_booth_mac_acc;
  localparam int ACC_W = 10;
  localparam int CNT_W = 4;

  logic clk;
  logic rst_n;

  booth_mac_acc_if #(.ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  booth_mac_acc #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               len;
    logic [15:0][3:0] m;
    logic [15:0][3:0] q;
    logic [15:0][1:0] gap;
    int               exp_acc;
    bit               exp_sat;
  } vec_t;

  vec_t vecs [8];
  int   n_tests;
  int   n_fail;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input int idx, input int stall);
    int   wait_cnt;
    vec_t v;
    v = vecs[idx];
    @(negedge clk);
    bus.start     = 1'b1;
    bus.len       = v.len[CNT_W-1:0];
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    if (v.len == 0) begin
      check("zero_len_in_ready", int'(bus.in_ready), 0);
      check("zero_len_out_valid", int'(bus.out_valid), 1);
    end else begin
      check("start_in_ready", int'(bus.in_ready), 1);
      check("start_busy", int'(bus.busy), 1);
      check("start_acc_cleared", int'(bus.acc_out), 0);
      check("start_sat_cleared", int'(bus.sat), 0);
      for (int k = 0; k < v.len; k++) begin
        bus.in_valid = 1'b0;
        repeat (int'(v.gap[k])) @(negedge clk);
        bus.m        = v.m[k];
        bus.q        = v.q[k];
        bus.in_valid = 1'b1;
        wait_cnt = 0;
        while (!bus.in_ready && wait_cnt < 20) begin
          @(negedge clk);
          wait_cnt++;
        end
        if (wait_cnt >= 20) check("in_ready_timeout", 0, 1);
        @(negedge clk);
      end
      bus.in_valid = 1'b0;
      check("out_valid_early", int'(bus.out_valid), 0);
      @(negedge clk);
      check("out_valid_rise", int'(bus.out_valid), 1);
    end
    check($sformatf("vec%0d_acc", idx), int'(bus.acc_out), v.exp_acc);
    check($sformatf("vec%0d_sat", idx), int'(bus.sat), int'(v.exp_sat));
    $display("[TB] job %0d len=%0d acc_out=%0d sat=%0b", idx, v.len, bus.acc_out, bus.sat);
    for (int s = 0; s < stall; s++) begin
      bus.start = 1'b1;
      bus.len   = 4'd1;
      @(negedge clk);
      check("stall_out_valid", int'(bus.out_valid), 1);
      check("stall_acc", int'(bus.acc_out), v.exp_acc);
    end
    bus.start     = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("release_out_valid", int'(bus.out_valid), 0);
    check("release_busy", int'(bus.busy), 0);
    if (stall > 0) begin
      @(negedge clk);
      check("stall_start_ignored", int'(bus.busy), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;

    for (int i = 0; i < 8; i++) begin
      vecs[i].len = 0;  vecs[i].m = '0; vecs[i].q = '0; vecs[i].gap = '0;
      vecs[i].exp_acc = 0; vecs[i].exp_sat = 1'b0;
    end
    // 3*2 + (-4)*5 + 7*7 = 35, back to back
    vecs[0].len = 3;
    vecs[0].m[0] = 4'h3; vecs[0].q[0] = 4'h2;
    vecs[0].m[1] = 4'hC; vecs[0].q[1] = 4'h5;
    vecs[0].m[2] = 4'h7; vecs[0].q[2] = 4'h7;
    vecs[0].exp_acc = 35;
    // same job, in_valid pattern 1,0,0,1,0,1
    vecs[1] = vecs[0];
    vecs[1].gap[1] = 2'd2; vecs[1].gap[2] = 2'd1;
    // 15 * 64 = 960 clamps to 511; 15 * (-56) = -840 clamps to -512
    vecs[2].len = 15; vecs[2].exp_acc = 511;  vecs[2].exp_sat = 1'b1;
    vecs[3].len = 15; vecs[3].exp_acc = -512; vecs[3].exp_sat = 1'b1;
    for (int k = 0; k < 15; k++) begin
      vecs[2].m[k] = 4'h8; vecs[2].q[k] = 4'h8;
      vecs[3].m[k] = 4'h8; vecs[3].q[k] = 4'h7;
    end
    vecs[4].len = 1; vecs[4].m[0] = 4'h1; vecs[4].q[0] = 4'h1; vecs[4].exp_acc = 1;
    vecs[5].len = 0; vecs[5].exp_acc = 0;
    // 7*(-8) + (-8)*(-8) + (-1)*(-1) + 5*(-3) = -56 + 64 + 1 - 15 = -6
    vecs[6].len = 4;
    vecs[6].m[0] = 4'h7; vecs[6].q[0] = 4'h8;
    vecs[6].m[1] = 4'h8; vecs[6].q[1] = 4'h8;
    vecs[6].m[2] = 4'hF; vecs[6].q[2] = 4'hF;
    vecs[6].m[3] = 4'h5; vecs[6].q[3] = 4'hD;
    vecs[6].gap[2] = 2'd3;
    vecs[6].exp_acc = -6;
    // follow-up after mid-job reset: 2*3 = 6
    vecs[7].len = 1; vecs[7].m[0] = 4'h2; vecs[7].q[0] = 4'h3; vecs[7].exp_acc = 6;

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.in_valid  = 1'b0;
    bus.m         = '0;
    bus.q         = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_in_ready", int'(bus.in_ready), 0);
    check("reset_out_valid", int'(bus.out_valid), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_acc", int'(bus.acc_out), 0);
    check("reset_sat", int'(bus.sat), 0);
    $display("[TB] reset idle checked");

    for (int i = 0; i < 7; i++) run_job(i, 0);

    // Result held under backpressure while start is asserted
    run_job(1, 5);

    // Reset with a product in flight
    @(negedge clk);
    bus.start = 1'b1;
    bus.len   = 4'd4;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.m        = 4'h3;
    bus.q        = 4'h3;
    bus.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mid_job_acc", int'(bus.acc_out), 9);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_in_ready", int'(bus.in_ready), 0);
    check("async_rst_out_valid", int'(bus.out_valid), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_acc", int'(bus.acc_out), 0);
    check("async_rst_sat", int'(bus.sat), 0);
    $display("[TB] mid-job reset acc_out=%0d busy=%0b", bus.acc_out, bus.busy);
    @(negedge clk);
    rst_n = 1'b1;
    run_job(7, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/booth_mac_acc.md
# booth_mac_acc

Sequential signed multiply-accumulate stage that sits directly downstream of the 4x4 Booth multiplier (`booth_multi_top`). It accepts a start command carrying a term count, then takes that many signed 4-bit operand pairs over a valid/ready handshake. Each pair goes through an internal `booth_multi_top` instance, and the 8-bit products are summed into a saturating accumulator. The final sum is presented on a valid/ready result port.

## Interface
- `ACC_W`, default 12: accumulator/result width in bits, two's complement, must be ≥ 9.
- `CNT_W`, default 4: width of the term-count input; maximum terms per job is 2^CNT_W − 1.
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: job start pulse; sampled only in IDLE.
- `len`  in  CNT_W: number of products in the job, sampled with `start`.
- `in_valid`  in  1: operand pair valid.
- `in_ready`  out  1: stage can accept an operand pair.
- `m`  in  4: signed multiplicand.
- `q`  in  4: signed multiplier.
- `out_valid`  out  1: result valid.
- `out_ready`  in  1: downstream accepts the result.
- `acc_out`  out  ACC_W: signed accumulated sum.
- `sat`  out  1: sticky flag; set if any addition in the job saturated.
- `busy`  out  1: high in ACC and DONE.

## Operation
- FSM states: IDLE, ACC, DONE.
- **IDLE.** `start`=1 clears acc, `sat`, and the pipeline valid bit, and loads `remaining <= len`.
  - `len`=0: go to DONE.
  - Otherwise: go to ACC.
- **ACC.**
  - `in_ready` = (`remaining` ≠ 0).
  - An operand pair is accepted on an edge where `in_valid && in_ready`. On that edge:
    - `prod_r <=` product from the `booth_multi_top` instance (M=`m`, Q=`q`), combinational on the live inputs.
    - `prod_v <= 1`.
    - `remaining` decrements.
  - When no pair is accepted, `prod_v <= 0`.
  - When `prod_v`=1, `acc <= sat_add(acc, sext(prod_r))`.
  - Full throughput: a new pair can be accepted on the same edge that the previous product is added.
  - Exit to DONE on the edge where `remaining`=0 and `prod_v`=1, i.e. the edge that adds the last product.
- **DONE.**
  - `out_valid`=1. `acc_out` and `sat` are held stable.
  - On `out_valid && out_ready`, go to IDLE.
- `start` in ACC or DONE is ignored. `in_valid` outside ACC is ignored, and `in_ready` is 0 there.
- **Arithmetic.**
  - `prod_r` is an 8-bit two's complement value, range −56..64.
  - The exact sum is computed at ACC_W+1 bits. If it is above 2^(ACC_W−1)−1 the result clamps to that value; if it is below −2^(ACC_W−1) it clamps to that value. Either clamp sets `sat`.
  - Accumulation continues from the clamped value.
- `acc_out` always reflects the acc register, so intermediate values are visible during ACC.

## Timing
- Reset values (async on `rst_n` low):
  - state IDLE
  - `acc`, `acc_out` = 0
  - `sat` = 0
  - `remaining` = 0
  - `prod_v` = 0
  - `in_ready`, `out_valid`, `busy` = 0
- `start` edge → `in_ready`=1 in the following cycle, when `len` ≠ 0.
- Last accepting edge T → product added and state DONE at edge T+1 → `out_valid` high from T+1 onward.
- `len`=0 → `out_valid` high after the `start` edge, with `acc_out`=0.
- Result handshake:
  - `out_valid` stays asserted until accepted.
  - Back-to-back job: `start` is honoured the cycle after acceptance, once the state is IDLE.
- `rst_n` low in any state, including mid-ACC with `prod_v`=1, aborts the job immediately. The in-flight product is discarded.

## Test plan
- Reset / idle: `rst_n` low for 3 cycles, then high with no stimulus → `in_ready`=0, `out_valid`=0, `busy`=0, `acc_out`=0, `sat`=0.
- Back-to-back: `len`=3, pairs (3,2), (−4,5), (7,7) on consecutive cycles with `out_ready`=1 → `acc_out`=35, `sat`=0, `out_valid` rises exactly one edge after the third accept.
- Bubbles and stall: same job with `in_valid` toggling 1,0,0,1,0,1 → same result 35. Then hold `out_ready`=0 for 5 cycles → `out_valid` and `acc_out`=35 stable; a `start` asserted meanwhile is ignored.
- Saturation (`ACC_W`=10):
  - `len`=15, 15× (−8,−8) → `acc_out`=511, `sat`=1.
  - `len`=15, 15× (−8,7) → `acc_out`=−512, `sat`=1.
  - Next job `len`=1, (1,1) → `acc_out`=1, `sat`=0.
- Zero length: `start` with `len`=0 → `in_ready` never high, `out_valid`=1 on the next cycle, `acc_out`=0.
- Reset mid-job: `len`=4, assert `rst_n` low after 2 accepts → all outputs return to reset values asynchronously. A subsequent `len`=1 job with (2,3) gives `acc_out`=6.
